rect_plotter: RTL and testbench

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/obstacle_pkg.sv | 23 ++
 rtl/rect_clip.sv | 46 ++++
 rtl/rect_plotter.sv | 145 ++++++++++++++
 tb/tb_rect_plotter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_pkg
// Brief    : Shared screen geometry, coordinate widths and FSM encoding for
//            the rectangle plotter.
// Revision : 1.0 - initial release
// ============================================================================
package obstacle_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COLOR_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : obstacle_pkg
`default_nettype wire

// File: rtl/rect_clip.sv
`default_nettype none
// ============================================================================
// Module   : rect_clip
// Brief    : Combinational clipping of a rectangle request against the
//            screen: inclusive end coordinates and an empty flag.
// Revision : 1.0 - initial release
// ============================================================================
module rect_clip
    import obstacle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [X_W-1:0] i_w,
    input  logic [Y_W-1:0] i_h,
    output logic [X_W-1:0] o_x_end,
    output logic [Y_W-1:0] o_y_end,
    output logic           o_empty
);

    localparam logic [8:0] c_X_MAX = 9'(SCREEN_W - 1);
    localparam logic [8:0] c_Y_MAX = 9'(SCREEN_H - 1);
    localparam logic [8:0] c_X_LIM = 9'(SCREEN_W);
    localparam logic [8:0] c_Y_LIM = 9'(SCREEN_H);

    logic [8:0] w_x_sum;
    logic [8:0] w_y_sum;
    logic [8:0] w_x_clip;
    logic [8:0] w_y_clip;

    // 9-bit sums cannot overflow; a zero size underflows but is flagged empty
    always_comb begin
        w_x_sum  = {1'b0, i_x} + {1'b0, i_w} - 9'd1;
        w_y_sum  = {2'b00, i_y} + {2'b00, i_h} - 9'd1;
        w_x_clip = (w_x_sum > c_X_MAX) ? c_X_MAX : w_x_sum;
        w_y_clip = (w_y_sum > c_Y_MAX) ? c_Y_MAX : w_y_sum;
        o_x_end  = X_W'(w_x_clip);
        o_y_end  = Y_W'(w_y_clip);
        o_empty  = (i_w == '0) || (i_h == '0) ||
                   ({1'b0, i_x} >= c_X_LIM) || ({2'b00, i_y} >= c_Y_LIM);
    end

endmodule : rect_clip
`default_nettype wire

// File: rtl/rect_plotter.sv
`default_nettype none
// ============================================================================
// Module   : rect_plotter
// Brief    : Accepts rectangle requests and streams one clipped pixel per
//            cycle in raster order to a frame-buffer adapter.
// Revision : 1.0 - initial release
// ============================================================================
module rect_plotter
    import obstacle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [X_W-1:0]     req_x,
    input  logic [Y_W-1:0]     req_y,
    input  logic [X_W-1:0]     req_w,
    input  logic [Y_W-1:0]     req_h,
    input  logic [COLOR_W-1:0] req_color,
    output logic [X_W-1:0]     xpos,
    output logic [Y_W-1:0]     ypos,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    state_t               r_state;
    state_t               w_state_next;

    logic [X_W-1:0]       r_xpos;
    logic [Y_W-1:0]       r_ypos;
    logic [COLOR_W-1:0]   r_color;
    logic [X_W-1:0]       r_x0;
    logic [X_W-1:0]       r_x_end;
    logic [Y_W-1:0]       r_y_end;
    logic                 r_plot;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;

    logic [X_W-1:0]       w_x_end;
    logic [Y_W-1:0]       w_y_end;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_last;

    rect_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .i_x     (req_x),
        .i_y     (req_y),
        .i_w     (req_w),
        .i_h     (req_h),
        .o_x_end (w_x_end),
        .o_y_end (w_y_end),
        .o_empty (w_empty)
    );

    // Next-state decode; the last pixel is the clipped bottom-right corner
    always_comb begin
        w_accept     = req_valid && r_ready;
        w_last       = (r_xpos == r_x_end) && (r_ypos == r_y_end);
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_empty ? ST_DONE : ST_DRAW;
            ST_DRAW: if (w_last)   w_state_next = ST_DONE;
            ST_DONE:               w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_plot  <= (w_state_next == ST_DRAW);
            r_done  <= (w_state_next == ST_DONE);
            r_busy  <= (w_state_next != ST_IDLE);
            r_ready <= (w_state_next == ST_IDLE);
        end
    end

    // Request latch and raster walk; position holds outside DRAW
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xpos  <= '0;
            r_ypos  <= '0;
            r_color <= '0;
            r_x0    <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x0    <= req_x;
                        r_x_end <= w_x_end;
                        r_y_end <= w_y_end;
                        if (!w_empty) begin
                            r_xpos  <= req_x;
                            r_ypos  <= req_y;
                            r_color <= req_color;
                        end
                    end
                end
                ST_DRAW: begin
                    if (!w_last) begin
                        if (r_xpos == r_x_end) begin
                            r_xpos <= r_x0;
                            r_ypos <= r_ypos + 1'b1;
                        end else begin
                            r_xpos <= r_xpos + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign xpos      = r_xpos;
    assign ypos      = r_ypos;
    assign color     = r_color;
    assign plot      = r_plot;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : rect_plotter
`default_nettype wire

// File: tb/tb_rect_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_plotter
// Brief    : Self-checking bench for rect_plotter with a pixel scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_plotter;

    localparam int c_SW = 160;
    localparam int c_SH = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [7:0] req_w;
    logic [6:0] req_h;
    logic [2:0] req_color;
    logic [7:0] xpos;
    logic [6:0] ypos;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_pix;

    rect_plotter #(.SCREEN_W(c_SW), .SCREEN_H(c_SH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_color (req_color),
        .xpos      (xpos),
        .ypos      (ypos),
        .color     (color),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Scoreboard model: push every clipped pixel of an accepted request
    function automatic void push_rect(int x, int y, int w, int h, logic [2:0] c);
        int xe;
        int ye;
        exp_done++;
        if (w == 0 || h == 0 || x >= c_SW || y >= c_SH) return;
        xe = x + w - 1;
        ye = y + h - 1;
        if (xe > c_SW - 1) xe = c_SW - 1;
        if (ye > c_SH - 1) ye = c_SH - 1;
        for (int yy = y; yy <= ye; yy++)
            for (int xx = x; xx <= xe; xx++)
                exp_q.push_back({8'(xx), 7'(yy), c});
    endfunction

    // Pixel/done monitor against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (plot) begin
                plot_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_unexpected got x=%0d y=%0d c=%b required none", xpos, ypos, color);
                end else begin
                    mon_pix = exp_q.pop_front();
                    if ({xpos, ypos, color} !== mon_pix) begin
                        failures++;
                        $display("FAIL pixel got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b",
                                 xpos, ypos, color, mon_pix[17:10], mon_pix[9:3], mon_pix[2:0]);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (exp_done == 0 || exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL done_pulse got done=1 required pending=%0d left_pixels=%0d", exp_done, exp_q.size());
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic send(input int x, input int y, input int w, input int h, input logic [2:0] c);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h); req_color = c;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_ready got ready=0 required ready=1 within 200 cycles");
        end
        push_rect(x, y, w, h, c);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (done_cnt < target) begin
            @(negedge clk);
            #1;
            n++;
            if (n > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
        #1;
        checks++;
        if ({plot, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got plot/done/busy=%b required 000", {plot, done, busy});
        end
        checks++;
        if ({xpos, ypos, color} !== 18'd0) begin
            failures++;
            $display("FAIL reset_pos got x=%0d y=%0d c=%b required 0 0 000", xpos, ypos, color);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_s;
        bit to;
        int d0;
        d0 = done_cnt;
        send(10, 20, 3, 2, 3'b100);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            exp_s = (k <= 6) ? 3'b101 : 3'b011;
            checks++;
            if ({plot, done, busy} !== exp_s) begin
                failures++;
                $display("FAIL basic_timing cycle=%0d got plot/done/busy=%b required %b", k, {plot, done, busy}, exp_s);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({req_ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL basic_return got ready/busy/done=%b required 100", {req_ready, busy, done});
        end
        wait_done(d0 + 1, 5, to);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_complete got left=%0d timeout=%0d required 0 0", exp_q.size(), to);
        end
    endtask

    task automatic test_clip();
        bit to;
        int p0;
        int d0;
        p0 = plot_cnt; d0 = done_cnt;
        send(158, 119, 5, 4, 3'b010);
        wait_done(d0 + 1, 50, to);
        checks++;
        if (to || plot_cnt - p0 != 2) begin
            failures++;
            $display("FAIL clip_count got plots=%0d timeout=%0d required 2", plot_cnt - p0, to);
        end
        p0 = plot_cnt;
        send(159, 119, 1, 1, 3'b111);
        wait_done(d0 + 2, 50, to);
        checks++;
        if (to || plot_cnt - p0 != 1 || xpos !== 8'd159 || ypos !== 7'd119) begin
            failures++;
            $display("FAIL corner got plots=%0d x=%0d y=%0d required 1 159 119", plot_cnt - p0, xpos, ypos);
        end
    endtask

    task automatic test_empty();
        int cases[4][4] = '{'{5, 5, 0, 3}, '{170, 5, 4, 3}, '{5, 5, 4, 0}, '{5, 120, 4, 3}};
        int p0;
        for (int i = 0; i < 4; i++) begin
            p0 = plot_cnt;
            send(cases[i][0], cases[i][1], cases[i][2], cases[i][3], 3'b001);
            @(negedge clk); #1;
            checks++;
            if ({plot, done} !== 2'b01) begin
                failures++;
                $display("FAIL empty_done case=%0d got plot/done=%b required 01", i, {plot, done});
            end
            @(negedge clk); #1;
            checks++;
            if ({req_ready, done} !== 2'b10 || plot_cnt != p0) begin
                failures++;
                $display("FAIL empty_idle case=%0d got ready/done=%b plots=%0d required 10 0", i, {req_ready, done}, plot_cnt - p0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        int d0;
        bit to;
        p0 = plot_cnt; d0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_x = 8'd0; req_y = 7'd0; req_w = 8'd4; req_h = 7'd4; req_color = 3'b001;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_ready got %b required 1", req_ready);
        end
        push_rect(0, 0, 4, 4, 3'b001);
        @(posedge clk); #1;
        req_x = 8'd10; req_y = 7'd10; req_w = 8'd4; req_h = 7'd4; req_color = 3'b110;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!req_ready && n < 100);
        checks++;
        if (n != 18 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL b2b_second_accept got cycle=%0d dones=%0d required 18 1", n, done_cnt - d0);
        end
        push_rect(10, 10, 4, 4, 3'b110);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(d0 + 2, 50, to);
        checks++;
        if (to || plot_cnt - p0 != 32 || done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL b2b_totals got plots=%0d dones=%0d required 32 2", plot_cnt - p0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        int d0;
        p0 = plot_cnt;
        send(20, 30, 8, 8, 3'b101);
        n = 0;
        while (plot_cnt - p0 < 5 && n < 50) begin
            @(negedge clk); #2;
            n++;
        end
        checks++;
        if (plot_cnt - p0 != 5) begin
            failures++;
            $display("FAIL rmid_reach got plots=%0d required 5", plot_cnt - p0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({plot, done, busy} !== 3'b000 || {xpos, ypos, color} !== 18'd0) begin
            failures++;
            $display("FAIL rmid_async got plot/done/busy=%b x=%0d y=%0d c=%b required 000 0 0 000",
                     {plot, done, busy}, xpos, ypos, color);
        end
        exp_q.delete();
        exp_done = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        p0 = plot_cnt; d0 = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (plot_cnt != p0 || done_cnt != d0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_after got plots=%0d dones=%0d ready=%b busy=%b required 0 0 1 0",
                     plot_cnt - p0, done_cnt - d0, req_ready, busy);
        end
    endtask

    task automatic test_full_screen();
        int p0;
        int d0;
        bit to;
        p0 = plot_cnt; d0 = done_cnt;
        send(0, 0, 160, 120, 3'b011);
        wait_done(d0 + 1, 20000, to);
        checks++;
        if (to || plot_cnt - p0 != 19200) begin
            failures++;
            $display("FAIL full_count got plots=%0d timeout=%0d required 19200", plot_cnt - p0, to);
        end
        checks++;
        if (xpos !== 8'd159 || ypos !== 7'd119 || color !== 3'b011) begin
            failures++;
            $display("FAIL full_last got x=%0d y=%0d c=%b required 159 119 011", xpos, ypos, color);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_full_screen();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rect_plotter
`default_nettype wire
